// File: rtl/tdes_round_ctrl_pkg.sv
// Shared types and constants for the TDES round sequencer and its key-select decoder.
package tdes_round_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] KEY_K1 = 2'd0;
    localparam logic [1:0] KEY_K2 = 2'd1;
    localparam logic [1:0] KEY_K3 = 2'd2;

    localparam logic [3:0] LAST_ROUND = 4'd15;

    localparam logic [1:0] PASS_LAST_DES  = 2'd0;
    localparam logic [1:0] PASS_LAST_TDES = 2'd2;

    function automatic logic [1:0] final_pass(input logic tdes_mode);
        return tdes_mode ? PASS_LAST_TDES : PASS_LAST_DES;
    endfunction

endpackage

// File: rtl/tdes_round_ctrl_if.sv
// Host handshake and datapath control bundle of the TDES round sequencer.
// TDES_ROUND_CTRL_ABORT_EN adds the abort request line.
interface tdes_round_ctrl_if;

`ifdef TDES_ROUND_CTRL_ABORT_EN
    logic       abort;
`endif
    logic       in_valid;
    logic       in_ready;
    logic       decrypt;
    logic       tdes_mode;
    logic       out_valid;
    logic       out_ready;
    logic       lr_en;
    logic       lr_sel;
    logic [3:0] round;
    logic [1:0] pass;
    logic [1:0] key_sel;
    logic       key_dec;
    logic       last_round;
    logic       busy;

    modport master (
`ifdef TDES_ROUND_CTRL_ABORT_EN
        output abort,
`endif
        output in_valid, decrypt, tdes_mode, out_ready,
        input  in_ready, out_valid, lr_en, lr_sel, round, pass,
        input  key_sel, key_dec, last_round, busy
    );

    modport slave (
`ifdef TDES_ROUND_CTRL_ABORT_EN
        input  abort,
`endif
        input  in_valid, decrypt, tdes_mode, out_ready,
        output in_ready, out_valid, lr_en, lr_sel, round, pass,
        output key_sel, key_dec, last_round, busy
    );

endinterface

// File: rtl/tdes_round_ctrl_key_sel.sv
// Maps the current pass and latched mode/direction to the key-schedule select
// and direction: EDE order K1/K2/K3 for encrypt, K3/K2/K1 for decrypt.
module tdes_key_sel
    import tdes_round_ctrl_pkg::*;
(
    input  logic [1:0] pass,
    input  logic       decrypt,
    input  logic       tdes_mode,
    output logic [1:0] key_sel,
    output logic       key_dec
);

    // Key and direction decode per pass
    always_comb begin
        key_sel = KEY_K1;
        key_dec = 1'b0;
        if (!tdes_mode) begin
            key_sel = KEY_K1;
            key_dec = decrypt;
        end else begin
            case (pass)
                2'd0: begin
                    key_sel = decrypt ? KEY_K3 : KEY_K1;
                    key_dec = decrypt;
                end
                2'd1: begin
                    key_sel = KEY_K2;
                    key_dec = ~decrypt;
                end
                2'd2: begin
                    key_sel = decrypt ? KEY_K1 : KEY_K3;
                    key_dec = decrypt;
                end
                default: begin
                    key_sel = KEY_K1;
                    key_dec = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/tdes_round_ctrl.sv
// Round sequencer for the TDES datapath: LOAD, 16 or 48 rounds, then DONE.
// Optional TDES_ROUND_CTRL_ABORT_EN adds an abort input that returns to IDLE.
module tdes_round_ctrl
    import tdes_round_ctrl_pkg::*;
#(
    parameter int ROUNDS = 16
) (
    input logic              clk,
    input logic              reset,
    tdes_round_ctrl_if.slave bus
);

    // Only 16-round passes are supported; the terminal index follows ROUNDS.
    localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

    state_e     state_r;
    state_e     state_s;
    logic [3:0] round_r;
    logic [3:0] round_s;
    logic [1:0] pass_r;
    logic [1:0] pass_s;
    logic       dec_r;
    logic       dec_s;
    logic       tdes_r;
    logic       tdes_s;
    logic       abort_s;
    logic [1:0] final_pass_s;
    logic [1:0] key_sel_s;
    logic       key_dec_s;

    logic       in_ready_s;
    logic       out_valid_s;
    logic       lr_en_s;
    logic       lr_sel_s;
    logic       busy_s;
    logic       last_round_s;

`ifdef TDES_ROUND_CTRL_ABORT_EN
    assign abort_s = bus.abort;
`else
    assign abort_s = 1'b0;
`endif

    assign final_pass_s = final_pass(tdes_r);

    tdes_key_sel u_key_sel (
        .pass      (pass_r),
        .decrypt   (dec_r),
        .tdes_mode (tdes_r),
        .key_sel   (key_sel_s),
        .key_dec   (key_dec_s)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Round/pass counters and the mode bits latched on accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            round_r <= 4'd0;
            pass_r  <= 2'd0;
            dec_r   <= 1'b0;
            tdes_r  <= 1'b0;
        end else begin
            round_r <= round_s;
            pass_r  <= pass_s;
            dec_r   <= dec_s;
            tdes_r  <= tdes_s;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_s = state_r;
        round_s = round_r;
        pass_s  = pass_r;
        dec_s   = dec_r;
        tdes_s  = tdes_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    state_s = LOAD;
                    round_s = 4'd0;
                    pass_s  = 2'd0;
                    dec_s   = bus.decrypt;
                    tdes_s  = bus.tdes_mode;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                round_s = 4'd0;
                pass_s  = 2'd0;
                if (abort_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = ROUND;
                end
            end
            ROUND: begin
                // Pass boundaries wrap straight into round 0 with no idle cycle
                if (abort_s) begin
                    state_s = IDLE;
                    round_s = 4'd0;
                    pass_s  = 2'd0;
                end else if (round_r != LAST_IDX) begin
                    round_s = round_r + 4'd1;
                end else if (pass_r < final_pass_s) begin
                    round_s = 4'd0;
                    pass_s  = pass_r + 2'd1;
                end else begin
                    state_s = DONE;
                    round_s = 4'd0;
                    pass_s  = 2'd0;
                end
            end
            DONE: begin
                round_s = 4'd0;
                pass_s  = 2'd0;
                if (abort_s || bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
                round_s = 4'd0;
                pass_s  = 2'd0;
            end
        endcase
    end

    // Output decode from registered state
    always_comb begin
        in_ready_s   = 1'b0;
        out_valid_s  = 1'b0;
        lr_en_s      = 1'b0;
        lr_sel_s     = 1'b0;
        busy_s       = 1'b0;
        last_round_s = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready_s = 1'b1;
            end
            LOAD: begin
                lr_en_s = 1'b1;
                busy_s  = 1'b1;
            end
            ROUND: begin
                lr_en_s      = 1'b1;
                lr_sel_s     = 1'b1;
                busy_s       = 1'b1;
                last_round_s = (round_r == LAST_ROUND);
            end
            DONE: begin
                out_valid_s = 1'b1;
            end
            default: begin
                in_ready_s = 1'b1;
            end
        endcase
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_s;
    assign bus.lr_en      = lr_en_s;
    assign bus.lr_sel     = lr_sel_s;
    assign bus.busy       = busy_s;
    assign bus.last_round = last_round_s;
    assign bus.round      = round_r;
    assign bus.pass       = pass_r;
    assign bus.key_sel    = busy_s ? key_sel_s : KEY_K1;
    assign bus.key_dec    = busy_s ? key_dec_s : 1'b0;

endmodule
